// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_sequencer
//  Description : Burst bus-cycle engine for a multiplexed address/data RTC
//                interface. One command reads or writes any subset of the
//                register slots selected by a mask. Every slot runs an address
//                phase and a data phase with programmable setup/strobe/hold
//                timing, followed by a chip-select-high gap.
//                Optional build macro: RTC_BCD_CHECK_EN (non-BCD flag per slot).
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer #(
    parameter int                         DATA_W   = 8,
    parameter int                         NUM_REGS = 9,
    parameter logic [NUM_REGS*DATA_W-1:0] ADDR_MAP = {8'h43, 8'h42, 8'h41, 8'h26, 8'h25,
                                                      8'h24, 8'h23, 8'h22, 8'h21},
    parameter int                         T_SU     = 1,
    parameter int                         T_STB    = 2,
    parameter int                         T_HD     = 1,
    parameter int                         T_GAP    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         op_write,
    input  logic [NUM_REGS-1:0]          reg_mask,
    input  logic [NUM_REGS*DATA_W-1:0]   wr_data,
    input  logic [DATA_W-1:0]            ad_in,
    output logic [DATA_W-1:0]            ad_out,
    output logic                         ad_oe,
    output logic                         a_d,
    output logic                         cs,
    output logic                         rd,
    output logic                         wr,
    output logic [NUM_REGS*DATA_W-1:0]   rd_data,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_REGS-1:0]          bcd_err
);

    localparam int c_SLOT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int c_T_MAX1 = (T_SU > T_STB) ? T_SU : T_STB;
    localparam int c_T_MAX2 = (T_HD > T_GAP) ? T_HD : T_GAP;
    localparam int c_T_MAX  = (c_T_MAX1 > c_T_MAX2) ? c_T_MAX1 : c_T_MAX2;
    localparam int c_PH_W   = (c_T_MAX > 1) ? $clog2(c_T_MAX) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR_SU  = 4'd1,
        S_ADDR_STB = 4'd2,
        S_ADDR_HD  = 4'd3,
        S_DATA_SU  = 4'd4,
        S_DATA_STB = 4'd5,
        S_DATA_HD  = 4'd6,
        S_GAP      = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t                       r_state, w_state_nx;
    logic [c_PH_W-1:0]            r_phase, w_phase_nx;
    logic [c_SLOT_W-1:0]          r_slot, w_slot_nx;
    logic                         r_op, w_op_nx;
    logic [NUM_REGS-1:0]          r_mask, w_mask_nx;
    logic [NUM_REGS*DATA_W-1:0]   r_wdata, w_wdata_nx;
    logic [c_SLOT_W:0]            w_hit;
    logic [c_SLOT_W:0]            w_from;
    logic                         w_phase_done;
    logic                         w_sample;

    logic [DATA_W-1:0]            r_ad_out, w_ad_out_nx;
    logic                         r_ad_oe, w_ad_oe_nx;
    logic                         r_a_d, w_a_d_nx;
    logic                         r_cs, w_cs_nx;
    logic                         r_rd, w_rd_nx;
    logic                         r_wr, w_wr_nx;
    logic                         r_busy, r_done;
    logic [NUM_REGS*DATA_W-1:0]   r_rd_data;

    // Lowest set mask bit at or above 'from'; MSB of the result flags a hit.
    function automatic logic [c_SLOT_W:0] find_slot(input logic [NUM_REGS-1:0] mask,
                                                     input logic [c_SLOT_W:0]   from);
        logic [c_SLOT_W:0] res;
        res = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) res = {1'b1, c_SLOT_W'(i)};
        end
        return res;
    endfunction

    // Final phase-counter value of each timed state.
    function automatic logic [c_PH_W-1:0] phase_last(input state_t s);
        logic [c_PH_W-1:0] v;
        v = '0;
        case (s)
            S_ADDR_SU,  S_DATA_SU:  v = c_PH_W'(T_SU - 1);
            S_ADDR_STB, S_DATA_STB: v = c_PH_W'(T_STB - 1);
            S_ADDR_HD,  S_DATA_HD:  v = c_PH_W'(T_HD - 1);
            S_GAP:                  v = c_PH_W'(T_GAP - 1);
            default:                v = '0;
        endcase
        return v;
    endfunction

    assign w_from       = {1'b0, r_slot} + {{c_SLOT_W{1'b0}}, 1'b1};
    assign w_phase_done = (r_phase == phase_last(r_state));
    assign w_sample     = (r_state == S_DATA_STB) && w_phase_done && !r_op;

    // Next-state, phase counter, slot walk and command latching.
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_slot_nx  = r_slot;
        w_op_nx    = r_op;
        w_mask_nx  = r_mask;
        w_wdata_nx = r_wdata;
        w_hit      = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_op_nx    = op_write;
                    w_mask_nx  = reg_mask;
                    w_wdata_nx = wr_data;
                    w_hit      = find_slot(reg_mask, '0);
                    w_slot_nx  = w_hit[c_SLOT_W-1:0];
                    w_phase_nx = '0;
                    w_state_nx = w_hit[c_SLOT_W] ? S_ADDR_SU : S_DONE;
                end
            end
            S_DONE: w_state_nx = S_IDLE;
            default: begin
                if (w_phase_done) begin
                    w_phase_nx = '0;
                    case (r_state)
                        S_ADDR_SU:  w_state_nx = S_ADDR_STB;
                        S_ADDR_STB: w_state_nx = S_ADDR_HD;
                        S_ADDR_HD:  w_state_nx = S_DATA_SU;
                        S_DATA_SU:  w_state_nx = S_DATA_STB;
                        S_DATA_STB: w_state_nx = S_DATA_HD;
                        S_DATA_HD:  w_state_nx = S_GAP;
                        default: begin
                            w_hit = find_slot(r_mask, w_from);
                            if (w_hit[c_SLOT_W]) begin
                                w_slot_nx  = w_hit[c_SLOT_W-1:0];
                                w_state_nx = S_ADDR_SU;
                            end else begin
                                w_state_nx = S_DONE;
                            end
                        end
                    endcase
                end else begin
                    w_phase_nx = r_phase + c_PH_W'(1);
                end
            end
        endcase
    end

    // Bus pin values for the state being entered, so the pins are registered.
    always_comb begin
        w_ad_out_nx = '0;
        w_ad_oe_nx  = 1'b0;
        w_a_d_nx    = 1'b1;
        w_cs_nx     = 1'b1;
        w_rd_nx     = 1'b1;
        w_wr_nx     = 1'b1;
        case (w_state_nx)
            S_ADDR_SU, S_ADDR_STB, S_ADDR_HD: begin
                w_cs_nx     = 1'b0;
                w_a_d_nx    = 1'b0;
                w_ad_oe_nx  = 1'b1;
                w_ad_out_nx = ADDR_MAP[int'(w_slot_nx)*DATA_W +: DATA_W];
                w_wr_nx     = (w_state_nx != S_ADDR_STB);
            end
            S_DATA_SU, S_DATA_STB, S_DATA_HD: begin
                w_cs_nx = 1'b0;
                if (w_op_nx) begin
                    w_ad_oe_nx  = 1'b1;
                    w_ad_out_nx = w_wdata_nx[int'(w_slot_nx)*DATA_W +: DATA_W];
                    w_wr_nx     = (w_state_nx != S_DATA_STB);
                end else begin
                    w_rd_nx     = (w_state_nx != S_DATA_STB);
                end
            end
            default: ;
        endcase
    end

    // Sequencer state and latched command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_slot  <= '0;
            r_op    <= 1'b0;
            r_mask  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_slot  <= w_slot_nx;
            r_op    <= w_op_nx;
            r_mask  <= w_mask_nx;
            r_wdata <= w_wdata_nx;
        end
    end

    // Registered bus pins and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ad_out <= '0;
            r_ad_oe  <= 1'b0;
            r_a_d    <= 1'b1;
            r_cs     <= 1'b1;
            r_rd     <= 1'b1;
            r_wr     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ad_out <= w_ad_out_nx;
            r_ad_oe  <= w_ad_oe_nx;
            r_a_d    <= w_a_d_nx;
            r_cs     <= w_cs_nx;
            r_rd     <= w_rd_nx;
            r_wr     <= w_wr_nx;
            r_busy   <= (w_state_nx != S_IDLE);
            r_done   <= (w_state_nx == S_DONE);
        end
    end

    // Capture the read byte on the last strobe-low cycle of a read data phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (w_sample) begin
            r_rd_data[int'(r_slot)*DATA_W +: DATA_W] <= ad_in;
        end
    end

`ifdef RTC_BCD_CHECK_EN
    logic [NUM_REGS-1:0] r_bcd_err;

    // Flag a sampled byte whose upper or lower nibble is not a decimal digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bcd_err <= '0;
        end else if (w_sample) begin
            r_bcd_err[r_slot] <= (ad_in[7:4] > 4'd9) || (ad_in[3:0] > 4'd9);
        end
    end

    assign bcd_err = r_bcd_err;
`else
    assign bcd_err = '0;
`endif

    assign ad_out  = r_ad_out;
    assign ad_oe   = r_ad_oe;
    assign a_d     = r_a_d;
    assign cs      = r_cs;
    assign rd      = r_rd;
    assign wr      = r_wr;
    assign rd_data = r_rd_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire
